// File: rtl/vga_timing_gen_if.sv
// Raster interface between the VGA timing source and the display block.
interface vga_timing_gen_if;
  logic [9:0] col;
  logic [9:0] row;
  logic       hsync;
  logic       vsync;
  logic       hnotactive;
  logic       vnotactive;
  logic       frame_start;
  logic       pix_en;

  modport master (output col, row, hsync, vsync, hnotactive, vnotactive, frame_start, pix_en);
  modport slave  (input  col, row, hsync, vsync, hnotactive, vnotactive, frame_start, pix_en);
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source: col/row counters, sync pulses, blanking flags, frame_start.
// Define VGA_PIXEL_DIV_EN to derive a half-rate pixel strobe from CLK; otherwise pix_en is 1.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input logic              CLK,
  input logic              RST,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit 10-bit counters");
  end

  localparam logic [9:0] C_H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] C_HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] C_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] C_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] C_VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] C_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] C_V_LAST = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC_S, H_BACK} hstate_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC_S, V_BACK} vstate_t;

  hstate_t    hstate;
  vstate_t    vstate;
  logic [9:0] col, row;
  logic       hsync, vsync, hnotactive, vnotactive, frame_start, pix_en;
  logic       eol, eof;
  logic [9:0] col_nxt, row_nxt;
`ifdef VGA_PIXEL_DIV_EN
  logic       phase;
`endif

  assign eol     = (col == C_H_LAST);
  assign eof     = eol && (row == C_V_LAST);
  assign col_nxt = eol ? '0 : col + 10'd1;
  assign row_nxt = eof ? '0 : (eol ? row + 10'd1 : row);

  // Flags are updated together with the counters so they always describe the shown col/row.
  always_ff @(posedge CLK) begin
    if (RST) begin
      col         <= '0;
      row         <= '0;
      hstate      <= H_ACT;
      vstate      <= V_ACT;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      hnotactive  <= 1'b0;
      vnotactive  <= 1'b0;
      frame_start <= 1'b0;
`ifdef VGA_PIXEL_DIV_EN
      phase       <= 1'b0;
      pix_en      <= 1'b0;
`else
      pix_en      <= 1'b1;
`endif
    end else begin
`ifdef VGA_PIXEL_DIV_EN
      // Strobe lands on the 2nd edge after release, then every other edge.
      phase  <= ~phase;
      pix_en <= phase;
`else
      pix_en <= 1'b1;
`endif
      frame_start <= pix_en && eof;
      if (pix_en) begin
        col <= col_nxt;
        unique case (hstate)
          H_ACT:    if (col_nxt == C_H_ACT)  begin hstate <= H_FRONT;  hnotactive <= 1'b1; end
          H_FRONT:  if (col_nxt == C_HS_BEG) begin hstate <= H_SYNC_S; hsync <= SYNC_POL; end
          H_SYNC_S: if (col_nxt == C_HS_END) begin hstate <= H_BACK;   hsync <= ~SYNC_POL; end
          H_BACK:   if (col_nxt == '0)       begin hstate <= H_ACT;    hnotactive <= 1'b0; end
        endcase
        if (eol) begin
          row <= row_nxt;
          unique case (vstate)
            V_ACT:    if (row_nxt == C_V_ACT)  begin vstate <= V_FRONT;  vnotactive <= 1'b1; end
            V_FRONT:  if (row_nxt == C_VS_BEG) begin vstate <= V_SYNC_S; vsync <= SYNC_POL; end
            V_SYNC_S: if (row_nxt == C_VS_END) begin vstate <= V_BACK;   vsync <= ~SYNC_POL; end
            V_BACK:   if (row_nxt == '0)       begin vstate <= V_ACT;    vnotactive <= 1'b0; end
          endcase
        end
      end
    end
  end

  assign vga.col         = col;
  assign vga.row         = row;
  assign vga.hsync       = hsync;
  assign vga.vsync       = vsync;
  assign vga.hnotactive  = hnotactive;
  assign vga.vnotactive  = vnotactive;
  assign vga.frame_start = frame_start;
  assign vga.pix_en      = pix_en;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size 640x480 instance for line timing, plus a shrunken instance for frame timing.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if big();
  vga_timing_gen_if sml();

  vga_timing_gen dut (.CLK(clk), .RST(rst), .vga(big.master));

  // 15 px/line (sync cols 10..12), 8 lines/frame (sync rows 5..6), 120 px/frame.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (.CLK(clk), .RST(rst), .vga(sml.master));

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       hs, vs, hn, vn, fs;
  } obs_t;

  typedef struct {
    int   delta;
    obs_t exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;

  localparam obs_t RST_OBS = '{col: 10'd0, row: 10'd0, hs: 1'b1, vs: 1'b1, hn: 1'b0, vn: 1'b0, fs: 1'b0};

  function automatic obs_t get_big();
    return '{col: big.col, row: big.row, hs: big.hsync, vs: big.vsync,
             hn: big.hnotactive, vn: big.vnotactive, fs: big.frame_start};
  endfunction

  function automatic obs_t get_sml();
    return '{col: sml.col, row: sml.row, hs: sml.hsync, vs: sml.vsync,
             hn: sml.hnotactive, vn: sml.vnotactive, fs: sml.frame_start};
  endfunction

  function automatic obs_t small_model(int kk);
    int c = kk % 15;
    int r = (kk / 15) % 8;
    obs_t o;
    o.col = 10'(c);
    o.row = 10'(r);
    o.hs  = !(c >= 10 && c <= 12);
    o.vs  = !(r >= 5 && r <= 6);
    o.hn  = (c >= 8);
    o.vn  = (r >= 4);
    o.fs  = (kk > 0) && (kk % 120 == 0);
    return o;
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got col=%0d row=%0d hs=%b vs=%b hn=%b vn=%b fs=%b, want col=%0d row=%0d hs=%b vs=%b hn=%b vn=%b fs=%b",
                 name, act.col, act.row, act.hs, act.vs, act.hn, act.vn, act.fs,
                 exp.col, exp.row, exp.hs, exp.vs, exp.hn, exp.vn, exp.fs);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel advance: wait for the strobe (bounded), take the edge, check the small instance.
  task automatic step();
    int n = 0;
    while (!big.pix_en && n < 4) begin
      tick();
      n++;
    end
    if (!big.pix_en) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pix_en_timeout: got pix_en=%b after %0d clocks, want 1", big.pix_en, n);
    end
    tick();
    k++;
    check_obs($sformatf("small_k%0d", k), get_sml(), small_model(k));
  endtask

  vec_t vecs[9];
  int   hs_lo, hn_hi, fs_big, fs_sml;

  initial begin
    vecs[0] = '{0,   RST_OBS};
    vecs[1] = '{639, '{10'd639, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{1,   '{10'd640, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[3] = '{15,  '{10'd655, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[4] = '{1,   '{10'd656, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[5] = '{95,  '{10'd751, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[6] = '{1,   '{10'd752, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{47,  '{10'd799, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[8] = '{1,   '{10'd0,   10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};

    rst = 1'b1;
    repeat (3) tick();
    check_obs("reset_small", get_sml(), RST_OBS);
    rst = 1'b0;

`ifdef VGA_PIXEL_DIV_EN
    check_int("pix_en_reset", int'(big.pix_en), 0);
    tick();
    check_int("pix_en_edge1", int'(big.pix_en), 0);
    tick();
    check_int("pix_en_edge2", int'(big.pix_en), 1);
    check_int("col_hold_div", int'(big.col), 0);
`else
    check_int("pix_en_const", int'(big.pix_en), 1);
`endif

    // One full line on the 640x480 instance.
    for (int i = 0; i < 9; i++) begin
      repeat (vecs[i].delta) step();
      check_obs($sformatf("line_vec%0d", i), get_big(), vecs[i].exp);
    end

    // Second line: pulse widths and frame_start counts (k runs 801..1600).
    hs_lo = 0; hn_hi = 0; fs_big = 0; fs_sml = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      if (big.hsync == 1'b0)   hs_lo++;
      if (big.hnotactive)      hn_hi++;
      if (big.frame_start)     fs_big++;
      if (sml.frame_start)     fs_sml++;
    end
    check_int("hsync_low_count", hs_lo, 96);
    check_int("hnotactive_count", hn_hi, 160);
    check_int("frame_start_big", fs_big, 0);
    check_int("frame_start_small", fs_sml, 7);
    check_int("row_after_2_lines", int'(big.row), 2);

    // Park the small instance on its last pixel, then reset across the would-be wrap.
    repeat (79) step();
    check_obs("small_last_pixel", get_sml(),
              '{10'd14, 10'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    check_obs("big_mid_line", get_big(),
              '{10'd79, 10'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b1;
    tick();
    check_obs("midframe_reset_big", get_big(), RST_OBS);
    check_obs("midframe_reset_small", get_sml(), RST_OBS);
    rst = 1'b0;
    k = 0;
    repeat (5) step();
    check_obs("restart_big", get_big(),
              '{10'd5, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
